// File: rtl/fg_pkg.sv
// Shared types and constants for the flow generator burst path.
package fg_pkg;

    localparam int unsigned FG_RATE_WIDTH  = 16;
    localparam int unsigned FG_LEN_WIDTH   = 32;
    localparam int unsigned FG_TOKEN_WIDTH = 48;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StSend = 2'd2
    } fg_state_e;

    // Size of the next burst; a zero burst length means "whatever is left".
    function automatic logic [FG_LEN_WIDTH-1:0] fg_burst_size(
        input logic [FG_LEN_WIDTH-1:0] burst_len,
        input logic [FG_LEN_WIDTH-1:0] remaining
    );
        if (burst_len == '0 || burst_len > remaining) begin
            return remaining;
        end
        return burst_len;
    endfunction

    // Rates at or above line rate (or degenerate fractions) skip pacing.
    function automatic logic fg_is_unlimited(
        input logic [FG_RATE_WIDTH-1:0] num,
        input logic [FG_RATE_WIDTH-1:0] denom
    );
        return (num == '0) || (denom == '0) || (num >= denom);
    endfunction

endpackage

// File: rtl/fg_rate_credit.sv
// Token accumulator pacing bursts to num/denom of line rate.
// Credit never exceeds the current burst cost, so idle time cannot be banked.
module fg_rate_credit
    import fg_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      load,
    input  logic                      add,
    input  logic                      sub,
    input  logic [FG_RATE_WIDTH-1:0]  num,
    input  logic [FG_TOKEN_WIDTH-1:0] cost,
    output logic                      credit_ok
);

    localparam int unsigned PadW = FG_TOKEN_WIDTH + 1 - FG_RATE_WIDTH;

    logic [FG_TOKEN_WIDTH-1:0] tokens_q, tokens_d;
    logic [FG_TOKEN_WIDTH:0]   num_ext;
    logic [FG_TOKEN_WIDTH:0]   sum;
    logic [FG_TOKEN_WIDTH:0]   spent;
    logic [FG_TOKEN_WIDTH:0]   cost_ext;

    // Next credit value: clear > load > spend > accrue, all saturated at cost.
    always_comb begin
        num_ext  = {{PadW{1'b0}}, num};
        cost_ext = {1'b0, cost};
        sum      = {1'b0, tokens_q} + num_ext;
        // Unlimited flows may spend without enough credit; floor at zero then.
        if (tokens_q >= cost) begin
            spent = {1'b0, tokens_q - cost} + num_ext;
        end else begin
            spent = num_ext;
        end
        tokens_d = tokens_q;
        if (clear) begin
            tokens_d = '0;
        end else if (load) begin
            tokens_d = cost;
        end else if (sub) begin
            tokens_d = (spent > cost_ext) ? cost : spent[FG_TOKEN_WIDTH-1:0];
        end else if (add) begin
            tokens_d = (sum > cost_ext) ? cost : sum[FG_TOKEN_WIDTH-1:0];
        end
    end

    // Credit register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tokens_q <= '0;
        end else begin
            tokens_q <= tokens_d;
        end
    end

    assign credit_ok = (tokens_q >= cost);

endmodule

// File: rtl/fg_fd_burst_gen.sv
// Splits one flow descriptor into paced burst descriptors.
// Optional statistics counters are enabled with FG_BURST_STATS_EN.
module fg_fd_burst_gen
    import fg_pkg::*;
#(
    parameter int unsigned DEST_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     input_fd_valid,
    output logic                     input_fd_ready,
    input  logic [DEST_WIDTH-1:0]    input_fd_dest,
    input  logic [FG_RATE_WIDTH-1:0] input_fd_rate_num,
    input  logic [FG_RATE_WIDTH-1:0] input_fd_rate_denom,
    input  logic [FG_LEN_WIDTH-1:0]  input_fd_len,
    input  logic [FG_LEN_WIDTH-1:0]  input_fd_burst_len,
    output logic                     output_bd_valid,
    input  logic                     output_bd_ready,
    output logic [DEST_WIDTH-1:0]    output_bd_dest,
    output logic [FG_LEN_WIDTH-1:0]  output_bd_len,
    output logic                     busy,
    output logic [FG_LEN_WIDTH-1:0]  bytes_remaining,
    output logic [31:0]              burst_count,
    output logic [47:0]              byte_count
);

    fg_state_e                 state_q, state_d;
    logic [DEST_WIDTH-1:0]     dest_q, dest_d;
    logic [FG_RATE_WIDTH-1:0]  num_q, num_d;
    logic [FG_RATE_WIDTH-1:0]  denom_q, denom_d;
    logic [FG_LEN_WIDTH-1:0]   burst_len_q, burst_len_d;
    logic [FG_LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic [FG_LEN_WIDTH-1:0]   burst_q, burst_d;
    logic [FG_TOKEN_WIDTH-1:0] cost_q, cost_d;
    logic                      first_q, first_d;
    logic                      unlimited_q, unlimited_d;

    logic [FG_LEN_WIDTH-1:0]   burst_calc;
    logic [FG_TOKEN_WIDTH-1:0] cost_calc;
    logic [FG_TOKEN_WIDTH-1:0] credit_cost;
    logic                      credit_ok;
    logic                      credit_clear, credit_load, credit_add, credit_sub;
    logic                      bd_fire;

    assign burst_calc = fg_burst_size(burst_len_q, remaining_q);
    assign cost_calc  = FG_TOKEN_WIDTH'(burst_calc) * FG_TOKEN_WIDTH'(denom_q);
    // During CALC the credit saturates against the burst about to be offered.
    assign credit_cost = (state_q == StCalc) ? cost_calc : cost_q;

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d      = state_q;
        dest_d       = dest_q;
        num_d        = num_q;
        denom_d      = denom_q;
        burst_len_d  = burst_len_q;
        remaining_d  = remaining_q;
        burst_d      = burst_q;
        cost_d       = cost_q;
        first_d      = first_q;
        unlimited_d  = unlimited_q;
        credit_clear = 1'b0;
        credit_load  = 1'b0;
        credit_add   = 1'b0;
        credit_sub   = 1'b0;

        input_fd_ready  = (state_q == StIdle);
        output_bd_valid = (state_q == StSend) && (unlimited_q || credit_ok);
        bd_fire         = output_bd_valid && output_bd_ready;

        unique case (state_q)
            StIdle: begin
                credit_clear = 1'b1;
                if (input_fd_valid) begin
                    dest_d      = input_fd_dest;
                    num_d       = input_fd_rate_num;
                    denom_d     = input_fd_rate_denom;
                    burst_len_d = input_fd_burst_len;
                    remaining_d = input_fd_len;
                    unlimited_d = fg_is_unlimited(input_fd_rate_num, input_fd_rate_denom);
                    first_d     = 1'b1;
                    // Zero-length flows are dropped without leaving IDLE.
                    if (input_fd_len != '0) begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                burst_d = burst_calc;
                cost_d  = cost_calc;
                // First burst of a flow goes out without waiting for credit.
                if (first_q) begin
                    credit_load = 1'b1;
                    first_d     = 1'b0;
                end else begin
                    credit_add = 1'b1;
                end
                state_d = StSend;
            end
            StSend: begin
                if (bd_fire) begin
                    credit_sub  = 1'b1;
                    remaining_d = remaining_q - burst_q;
                    state_d     = (remaining_q != burst_q) ? StCalc : StIdle;
                end else begin
                    credit_add = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            dest_q      <= '0;
            num_q       <= '0;
            denom_q     <= '0;
            burst_len_q <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            cost_q      <= '0;
            first_q     <= 1'b0;
            unlimited_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            num_q       <= num_d;
            denom_q     <= denom_d;
            burst_len_q <= burst_len_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            cost_q      <= cost_d;
            first_q     <= first_d;
            unlimited_q <= unlimited_d;
        end
    end

    fg_rate_credit u_rate_credit (
        .clk       (clk),
        .rst       (rst),
        .clear     (credit_clear),
        .load      (credit_load),
        .add       (credit_add),
        .sub       (credit_sub),
        .num       (num_q),
        .cost      (credit_cost),
        .credit_ok (credit_ok)
    );

    assign output_bd_dest  = dest_q;
    assign output_bd_len   = burst_q;
    assign busy            = (state_q != StIdle);
    assign bytes_remaining = (state_q == StIdle) ? '0 : remaining_q;

`ifdef FG_BURST_STATS_EN
    logic [31:0] burst_count_q;
    logic [47:0] byte_count_q;

    // Running totals of issued bursts and bytes; both wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            burst_count_q <= '0;
            byte_count_q  <= '0;
        end else if (bd_fire) begin
            burst_count_q <= burst_count_q + 32'd1;
            byte_count_q  <= byte_count_q + 48'(burst_q);
        end
    end

    assign burst_count = burst_count_q;
    assign byte_count  = byte_count_q;
`else
    assign burst_count = '0;
    assign byte_count  = '0;
`endif

endmodule

// File: doc/fg_fd_burst_gen.md
# fg_fd_burst_gen

Flow-descriptor consumer for the flow generator. It accepts one flow descriptor at a time: destination, rate as a fraction num/denom of line rate in bytes per cycle, total length, and burst length. It splits the flow into burst descriptors and paces them with a credit accumulator so the long-run rate matches num/denom. It sits downstream of the flow-descriptor FIFO and upstream of the per-destination packet/burst engines.

## Interface

Parameters:
- DEST_WIDTH, 8, destination field width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- input_fd_valid  in  1  flow descriptor valid
- input_fd_ready  out  1  flow descriptor accepted when high with valid
- input_fd_dest  in  DEST_WIDTH  flow destination
- input_fd_rate_num  in  16  rate numerator
- input_fd_rate_denom  in  16  rate denominator
- input_fd_len  in  32  flow length, bytes
- input_fd_burst_len  in  32  burst length, bytes
- output_bd_valid  out  1  burst descriptor valid
- output_bd_ready  in  1  burst descriptor accepted
- output_bd_dest  out  DEST_WIDTH  burst destination (latched fd dest)
- output_bd_len  out  32  burst length, bytes
- busy  out  1  high when not IDLE
- bytes_remaining  out  32  flow bytes not yet issued
- burst_count  out  32  bursts issued since reset (see Configuration)
- byte_count  out  48  bytes issued since reset (see Configuration)

## Operation

- States: IDLE, CALC, SEND.
- **IDLE**: input_fd_ready=1. On handshake, latch dest/num/denom/burst_len and set remaining=len. Go to CALC, or stay in IDLE if len==0 (descriptor dropped, no output).
- **CALC**:
  - burst = min(burst_len, remaining); burst_len==0 means burst = remaining.
  - cost = burst × denom (48-bit).
  - First burst of a flow: tokens preset to cost.
  - Go to SEND.
- **SEND**: output_bd_valid = (tokens ≥ cost) or unlimited.
  - On handshake: remaining -= burst; tokens = tokens − cost + num.
  - Then go to CALC if remaining > 0, else IDLE.
- **Unlimited mode**: num==0, denom==0, or num ≥ denom. Pacing is bypassed and tokens are ignored.
- **Tokens**: 48-bit unsigned. +num every cycle in CALC/SEND except the handshake cycle (handled above). Saturate at cost, so no credit is banked beyond one burst. Cleared in IDLE.
- output_bd_dest and output_bd_len are stable while valid is high.
- bytes_remaining reflects the latched remaining; it is 0 in IDLE.

## Timing

- Reset (rst=0 at an edge): state IDLE, input_fd_ready=1, output_bd_valid=0, busy=0, output_bd_dest=0, output_bd_len=0, bytes_remaining=0, tokens=0, burst_count=0, byte_count=0.
- Reset mid-flow aborts the current flow immediately; nothing further is emitted.
- fd accepted at cycle 0 → CALC at cycle 1 → earliest output_bd_valid at cycle 2.
- Unlimited back-to-back bursts: one every 2 cycles (SEND, CALC).
- Paced spacing between handshakes is ceil(cost/num) cycles, provided ready is high when valid rises.
- Once valid is high it stays high until the handshake; the pacing wait applies only before assertion.
- input_fd_ready is low throughout CALC/SEND, so a descriptor is never accepted in the same cycle a flow's last burst completes. The next accept occurs in IDLE at the earliest one cycle later.

## Configuration

- FG_BURST_STATS_EN defined: burst_count increments by 1 and byte_count increments by output_bd_len on each output handshake. Both wrap modulo their width.
- Macro undefined: burst_count and byte_count are tied to 0, and the counter logic is not synthesized.

## Structure

- Shared package fg_pkg holds:
  - the state enum (IDLE/CALC/SEND)
  - FG_RATE_WIDTH=16, FG_LEN_WIDTH=32, FG_TOKEN_WIDTH=48
- Sub-module fg_rate_credit implements the token accumulator. Inputs: load-cost, add num, subtract on handshake, saturate, clear. Output: credit_ok.

## Test plan

- Unlimited, len=300, burst_len=100, num=1, denom=1, ready=1 → bd_len 100,100,100 at cycles 2,4,6; back to IDLE at cycle 7.
- Paced, len=300, burst_len=100, num=1, denom=2, ready=1 → handshakes at cycles 2, 202, 402.
- Remainder, len=250, burst_len=100, unlimited → bd_len 100,100,50. burst_len=0 → single bd_len 250.
- len=0 → no output_bd_valid; input_fd_ready stays 1; a second fd is accepted the next cycle.
- Backpressure: ready=0 for 10 cycles while valid → dest/len held stable; exactly one burst counted when ready rises.
- rst=0 asserted during SEND with remaining=200 → next cycle valid=0, busy=0, bytes_remaining=0. With FG_BURST_STATS_EN, counters read 0.
